ppl_fetch_ctrl: RTL
===================

# ppl_fetch_ctrl

Sequencer for the pipeline fetch stage. It owns the program-counter register and drives the fetch stage's next-PC select, so the fetch stage stays purely combinational. It also drives the IF/ID pipeline-register write enable and flush. It resolves start-up, load-use stalls, control-flow redirects and halt, and keeps two saturating performance counters.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded by reset.
- STARTUP_CYCLES, 2, cycles held in INIT after reset release before the first fetch; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  reset, synchronous, active-low.
- stall  in  1  load-use stall request from the hazard unit (ID stage).
- brTaken  in  1  conditional branch resolved taken in ID.
- jrTaken  in  1  jr decoded in ID.
- jalTaken  in  1  j/jal decoded in ID.
- haltIn  in  1  halt instruction decoded in ID.
- nextPc  in  32  selected next PC returned by the fetch stage mux.
- pc  out  32  current PC register, fed to the fetch stage pcIn.
- pcSrc  out  2  fetch mux select: 00 pc+4, 01 branch, 10 jr, 11 jal.
- pcWrite  out  1  PC register loads nextPc this edge.
- ifidWrite  out  1  IF/ID register load enable.
- ifidFlush  out  1  IF/ID register loads a bubble (nop) this edge.
- halted  out  1  controller is in HALT.
- conflict  out  1  sticky flag: more than one redirect request was seen in one cycle.
- stallCount  out  16  saturating count of stalled cycles.
- redirectCount  out  16  saturating count of taken redirects.

## Operation

The controller has four states: INIT, RUN, STALL and HALT.

**Reset** (resetn=0 at an edge):
- State goes to INIT and pc = RESET_PC.
- Startup counter = 0; stallCount = redirectCount = 0; conflict = 0.
- Reset mid-operation behaves identically, from any state.

**INIT**
- Outputs: pcWrite=0, ifidWrite=0, ifidFlush=1, pcSrc=00.
- The startup counter increments each cycle. After STARTUP_CYCLES cycles the state goes to RUN.
- All requests (stall, brTaken, jrTaken, jalTaken, haltIn) are ignored.

**RUN and STALL** apply the following priority each cycle, highest first:
1. **haltIn:** pcWrite=0, ifidWrite=0, ifidFlush=1. Next state HALT. Any redirect or stall in the same cycle is dropped.
2. **stall:** pcWrite=0, ifidWrite=0, ifidFlush=0, pcSrc=00. Next state STALL. stallCount increments. A redirect in the same cycle is ignored; ID re-presents it after the stall clears.
3. **Redirect** (any of jrTaken, jalTaken, brTaken):
   - pcSrc selects the request by priority jr(10) > jal(11) > br(01).
   - pcWrite=1, ifidWrite=1, ifidFlush=1 (squashes the wrong-path instruction).
   - redirectCount increments. Next state RUN.
   - If two or more requests are asserted, conflict is set to 1 and stays set until reset.
4. **Otherwise:** pcSrc=00, pcWrite=1, ifidWrite=1, ifidFlush=0. Next state RUN.

**PC register:** pc <= nextPc on an edge with pcWrite=1; otherwise it holds.

**HALT**
- Outputs: pcWrite=0, ifidWrite=0, ifidFlush=1, halted=1.
- The state is left only by reset.

**Counters**
- Both counters are 16-bit and saturate at 16'hFFFF; they never wrap.
- They count only in RUN/STALL, under the conditions above.

## Timing

- pcSrc, pcWrite, ifidWrite and ifidFlush are combinational from the current state and the current-cycle request inputs. They are valid in the same cycle and act at the next edge.
- pc, halted, conflict and both counters are registered.
- Redirect latency: a request in cycle N produces pc = target after edge N. The IF/ID register holds a bubble after the same edge, so the redirect penalty is 1 cycle.
- Stall: each cycle with stall=1 holds pc and IF/ID for exactly that cycle. Deasserting stall resumes in that same cycle.
- Reset values of the combinational outputs (INIT): pcSrc=00, pcWrite=0, ifidWrite=0, ifidFlush=1.
- Reset values of the registered outputs: pc=RESET_PC, halted=0, conflict=0, stallCount=0, redirectCount=0.
- The first fetch of RESET_PC is latched into IF/ID on the edge that ends INIT+1, that is, the first RUN cycle.

## Test plan

1. **Reset and start-up.** Hold resetn=0 for 3 cycles, then release with STARTUP_CYCLES=2.
   - pc=0 and pcWrite=0 for 2 cycles.
   - The first RUN cycle shows pcWrite=1, pcSrc=00.
   - After the next edge, pc=4 (with the bench returning nextPc = pc+4).
2. **Load-use stall.** In RUN at pc=0x20, assert stall for 2 cycles.
   - pc holds 0x20, ifidWrite=0, stallCount=2.
   - After release, pc advances to 0x24.
3. **Branch redirect.** brTaken=1 with branch target 0x100.
   - pcSrc=01, ifidFlush=1.
   - pc=0x100 after the edge; redirectCount=1.
4. **Simultaneous requests.**
   - jrTaken=1 with brTaken=1: pcSrc=10 and conflict=1, and conflict stays set afterward.
   - stall=1 with jalTaken=1: pc holds and redirectCount is unchanged.
5. **Halt.** haltIn=1 together with jalTaken=1.
   - halted=1 and pc frozen for 10+ cycles.
   - Apply resetn=0: pc=RESET_PC, state INIT.
6. **Saturation and mid-stall reset.**
   - Force 65,540 stall cycles: stallCount=16'hFFFF.
   - Assert resetn=0 during the stall: all counters return to 0.

Source files
------------

// File: rtl/ppl_fetch_ctrl_if.sv
// Fetch-stage control bundle: hazard/redirect requests in, PC and IF/ID controls out.
// The slave side is the fetch controller; the master side is the surrounding pipeline.
interface ppl_fetch_ctrl_if;
    logic        stall;
    logic        brTaken;
    logic        jrTaken;
    logic        jalTaken;
    logic        haltIn;
    logic [31:0] nextPc;
    logic [31:0] pc;
    logic [1:0]  pcSrc;
    logic        pcWrite;
    logic        ifidWrite;
    logic        ifidFlush;
    logic        halted;
    logic        conflict;
    logic [15:0] stallCount;
    logic [15:0] redirectCount;

    modport master (
        output stall, brTaken, jrTaken, jalTaken, haltIn, nextPc,
        input  pc, pcSrc, pcWrite, ifidWrite, ifidFlush, halted, conflict,
               stallCount, redirectCount
    );

    modport slave (
        input  stall, brTaken, jrTaken, jalTaken, haltIn, nextPc,
        output pc, pcSrc, pcWrite, ifidWrite, ifidFlush, halted, conflict,
               stallCount, redirectCount
    );
endinterface

// File: rtl/ppl_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC register, selects the next PC source and
// controls the IF/ID register across start-up, stalls, redirects and halt.
module ppl_fetch_ctrl #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          STARTUP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              resetn,
    ppl_fetch_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [1:0] SRC_PC4 = 2'b00;
    localparam logic [1:0] SRC_BR  = 2'b01;
    localparam logic [1:0] SRC_JR  = 2'b10;
    localparam logic [1:0] SRC_JAL = 2'b11;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_startup_cnt;
    logic [31:0] r_pc;
    logic        r_conflict;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_redirect_cnt;

    logic [1:0]  w_pc_src;
    logic        w_pc_write;
    logic        w_ifid_write;
    logic        w_ifid_flush;
    logic        w_stall_inc;
    logic        w_redirect_inc;
    logic        w_conflict_set;
    logic        w_redirect;
    logic [1:0]  w_req_count;

    assign w_redirect  = bus.jrTaken | bus.jalTaken | bus.brTaken;
    assign w_req_count = {1'b0, bus.jrTaken} + {1'b0, bus.jalTaken} + {1'b0, bus.brTaken};

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        w_next_state   = r_state;
        w_pc_src       = SRC_PC4;
        w_pc_write     = 1'b0;
        w_ifid_write   = 1'b0;
        w_ifid_flush   = 1'b1;
        w_stall_inc    = 1'b0;
        w_redirect_inc = 1'b0;
        w_conflict_set = 1'b0;

        case (r_state)
            S_INIT: begin
                if (r_startup_cnt == 4'(STARTUP_CYCLES - 1)) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN, S_STALL: begin
                if (bus.haltIn) begin
                    w_next_state = S_HALT;
                end else if (bus.stall) begin
                    // A redirect seen here is dropped; ID re-presents it once the stall clears.
                    w_ifid_flush = 1'b0;
                    w_stall_inc  = 1'b1;
                    w_next_state = S_STALL;
                end else if (w_redirect) begin
                    if (bus.jrTaken)       w_pc_src = SRC_JR;
                    else if (bus.jalTaken) w_pc_src = SRC_JAL;
                    else                   w_pc_src = SRC_BR;
                    w_pc_write     = 1'b1;
                    w_ifid_write   = 1'b1;
                    w_redirect_inc = 1'b1;
                    w_conflict_set = (w_req_count >= 2'd2);
                    w_next_state   = S_RUN;
                end else begin
                    w_pc_write   = 1'b1;
                    w_ifid_write = 1'b1;
                    w_ifid_flush = 1'b0;
                    w_next_state = S_RUN;
                end
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!resetn) begin
            r_state        <= S_INIT;
            r_startup_cnt  <= 4'd0;
            r_pc           <= RESET_PC;
            r_conflict     <= 1'b0;
            r_stall_cnt    <= 16'd0;
            r_redirect_cnt <= 16'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_INIT) begin
                r_startup_cnt <= r_startup_cnt + 4'd1;
            end
            if (w_pc_write) begin
                r_pc <= bus.nextPc;
            end
            if (w_conflict_set) begin
                r_conflict <= 1'b1;
            end
            if (w_stall_inc && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_redirect_inc && (r_redirect_cnt != 16'hFFFF)) begin
                r_redirect_cnt <= r_redirect_cnt + 16'd1;
            end
        end
    end

    assign bus.pc            = r_pc;
    assign bus.pcSrc         = w_pc_src;
    assign bus.pcWrite       = w_pc_write;
    assign bus.ifidWrite     = w_ifid_write;
    assign bus.ifidFlush     = w_ifid_flush;
    assign bus.halted        = (r_state == S_HALT);
    assign bus.conflict      = r_conflict;
    assign bus.stallCount    = r_stall_cnt;
    assign bus.redirectCount = r_redirect_cnt;

endmodule
